// File: rtl/rv32_pkg.sv
// rv32_pkg: shared datapath width, load funct3 encodings and writeback grant type.
package rv32_pkg;
  localparam int XLEN = 32;
  localparam logic [2:0] LB  = 3'b000;
  localparam logic [2:0] LH  = 3'b001;
  localparam logic [2:0] LW  = 3'b010;
  localparam logic [2:0] LBU = 3'b100;
  localparam logic [2:0] LHU = 3'b101;
  typedef enum logic [1:0] {GRANT_NONE, GRANT_ALU, GRANT_LSU} grant_e;
endpackage

// File: rtl/rv32_load_align.sv
// rv32_load_align: extracts and sign/zero-extends load data from an aligned word, flagging bad loads.
module rv32_load_align import rv32_pkg::*; (
  input  logic [XLEN-1:0] data,
  input  logic [1:0]      addr_lo,
  input  logic [2:0]      funct3,
  output logic [XLEN-1:0] value,
  output logic            err
);
  logic [7:0]  b;
  logic [15:0] h;
  assign b = data[{addr_lo, 3'b000} +: 8];
  assign h = addr_lo[1] ? data[31:16] : data[15:0];
  always_comb begin
    value = '0;
    err = 1'b0;
    case (funct3)
      LB:  value = {{(XLEN-8){b[7]}}, b};
      LBU: value = {{(XLEN-8){1'b0}}, b};
      LH:  begin value = {{(XLEN-16){h[15]}}, h}; err = addr_lo[0]; end
      LHU: begin value = {{(XLEN-16){1'b0}}, h}; err = addr_lo[0]; end
      LW:  begin value = data; err = |addr_lo; end
      default: err = 1'b1;
    endcase
  end
endmodule

// File: rtl/rv32_writeback.sv
// rv32_writeback: arbitrates ALU/LSU results onto the register file write port.
// Define WB_RETIRE_CNT_EN to build the accepted-transaction counter.
module rv32_writeback #(
  parameter int XLEN = rv32_pkg::XLEN,
  parameter int ALU_STARVE_LIMIT = 2
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            alu_valid,
  output logic            alu_ready,
  input  logic [4:0]      alu_rd,
  input  logic [XLEN-1:0] alu_value,
  input  logic            lsu_valid,
  output logic            lsu_ready,
  input  logic [4:0]      lsu_rd,
  input  logic [XLEN-1:0] lsu_data,
  input  logic [1:0]      lsu_addr_lo,
  input  logic [2:0]      lsu_funct3,
  output logic [4:0]      rd_address,
  output logic [XLEN-1:0] rd_value,
  output logic            load_err,
  output logic [31:0]     retire_count
);
  import rv32_pkg::*;
  localparam int WW = $clog2(ALU_STARVE_LIMIT + 1);
  localparam logic [WW-1:0] LIMIT = WW'(ALU_STARVE_LIMIT);
  logic [WW-1:0]   alu_wait;
  logic [XLEN-1:0] ld_value;
  logic            ld_err;
  grant_e          grant;
  rv32_load_align u_align (
    .data(lsu_data),
    .addr_lo(lsu_addr_lo),
    .funct3(lsu_funct3),
    .value(ld_value),
    .err(ld_err)
  );
  // LSU wins by default; a starved ALU takes the port once alu_wait saturates.
  always_comb begin
    grant = (alu_valid && (!lsu_valid || alu_wait == LIMIT)) ? GRANT_ALU :
            lsu_valid ? GRANT_LSU : GRANT_NONE;
    alu_ready = grant == GRANT_ALU;
    lsu_ready = grant == GRANT_LSU;
  end
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      alu_wait   <= '0;
      rd_address <= '0;
      rd_value   <= '0;
      load_err   <= 1'b0;
    end else begin
      alu_wait   <= alu_ready ? '0 : (alu_valid && alu_wait != LIMIT) ? alu_wait + WW'(1) : alu_wait;
      rd_address <= alu_ready ? alu_rd : (lsu_ready && !ld_err) ? lsu_rd : '0;
      rd_value   <= alu_ready ? alu_value : (lsu_ready && !ld_err) ? ld_value : '0;
      load_err   <= lsu_ready && ld_err;
    end
  end
`ifdef WB_RETIRE_CNT_EN
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) retire_count <= '0;
    else if (alu_ready || lsu_ready) retire_count <= retire_count + 32'd1;
  end
`else
  assign retire_count = '0;
`endif
endmodule

// File: tb/tb_rv32_writeback.sv
// tb_rv32_writeback: directed and short random stimulus checked against a behavioural model.
module tb_rv32_writeback;
  localparam int LIMIT = 2;
  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        alu_valid = 1'b0, lsu_valid = 1'b0;
  logic        alu_ready, lsu_ready, load_err;
  logic [4:0]  alu_rd = '0, lsu_rd = '0, rd_address;
  logic [31:0] alu_value = '0, lsu_data = '0, rd_value, retire_count;
  logic [1:0]  lsu_addr_lo = '0;
  logic [2:0]  lsu_funct3 = '0;
  int total = 0, bad = 0;
  bit started = 1'b0;

  rv32_writeback #(.XLEN(32), .ALU_STARVE_LIMIT(LIMIT)) dut (
    .clk(clk), .reset_n(reset_n),
    .alu_valid(alu_valid), .alu_ready(alu_ready), .alu_rd(alu_rd), .alu_value(alu_value),
    .lsu_valid(lsu_valid), .lsu_ready(lsu_ready), .lsu_rd(lsu_rd), .lsu_data(lsu_data),
    .lsu_addr_lo(lsu_addr_lo), .lsu_funct3(lsu_funct3),
    .rd_address(rd_address), .rd_value(rd_value), .load_err(load_err),
    .retire_count(retire_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: returns {err, value}; a bad load writes nothing so its value is 0.
  function automatic logic [32:0] model_load(input logic [31:0] d, input logic [1:0] a, input logic [2:0] f);
    logic [31:0] bv, hv, v;
    logic e;
    bv = (d >> (8 * a)) & 32'hFF;
    hv = (d >> (16 * (a / 2))) & 32'hFFFF;
    case (f)
      3'd0: v = bv[7] ? (bv | 32'hFFFF_FF00) : bv;
      3'd4: v = bv;
      3'd1: v = hv[15] ? (hv | 32'hFFFF_0000) : hv;
      3'd5: v = hv;
      3'd2: v = d;
      default: v = 0;
    endcase
    e = (f == 3'd1 || f == 3'd5) ? a[0] : (f == 3'd2) ? (a != 0) : !(f == 3'd0 || f == 3'd4);
    return {e, e ? 32'd0 : v};
  endfunction

  int          m_wait = 0;
  logic [4:0]  m_addr = '0;
  logic [31:0] m_val = '0, m_cnt = '0;
  logic        m_err = 1'b0;
  logic        m_ag, m_lg;
  logic [32:0] m_ld;
  assign m_ag = alu_valid && (!lsu_valid || m_wait >= LIMIT);
  assign m_lg = lsu_valid && !m_ag;
  assign m_ld = model_load(lsu_data, lsu_addr_lo, lsu_funct3);

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      m_wait <= 0; m_addr <= '0; m_val <= '0; m_err <= 1'b0; m_cnt <= '0;
    end else begin
      m_wait <= m_ag ? 0 : alu_valid ? ((m_wait + 1 > LIMIT) ? LIMIT : m_wait + 1) : m_wait;
      m_addr <= m_ag ? alu_rd : (m_lg && !m_ld[32]) ? lsu_rd : 5'd0;
      m_val  <= m_ag ? alu_value : m_lg ? m_ld[31:0] : 32'd0;
      m_err  <= m_lg && m_ld[32];
      m_cnt  <= m_cnt + ((m_ag || m_lg) ? 32'd1 : 32'd0);
    end
  end

  always @(negedge clk) begin
    if (started && reset_n) begin
      check("alu_ready", {31'd0, alu_ready}, {31'd0, m_ag});
      check("lsu_ready", {31'd0, lsu_ready}, {31'd0, m_lg});
      check("rd_address", {27'd0, rd_address}, {27'd0, m_addr});
      check("rd_value", rd_value, m_val);
      check("load_err", {31'd0, load_err}, {31'd0, m_err});
`ifdef WB_RETIRE_CNT_EN
      check("retire_count", retire_count, m_cnt);
`else
      check("retire_count", retire_count, 32'd0);
`endif
    end
  end

  task automatic idle();
    alu_valid = 1'b0; lsu_valid = 1'b0;
  endtask

  task automatic next();
    @(posedge clk); #1;
  endtask

  // One load offered alone; the write (or error) appears the following cycle.
  task automatic do_load(input string name, input logic [2:0] f, input logic [1:0] lo, input logic [4:0] rd,
                         input logic [31:0] ev, input logic ee);
    lsu_valid = 1'b1; lsu_data = 32'h80F0_1234; lsu_addr_lo = lo; lsu_funct3 = f; lsu_rd = rd;
    @(negedge clk); check({name, "_ready"}, {31'd0, lsu_ready}, 32'd1);
    next(); idle();
    @(negedge clk);
    check({name, "_value"}, rd_value, ev);
    check({name, "_err"}, {31'd0, load_err}, {31'd0, ee});
    check({name, "_addr"}, {27'd0, rd_address}, ee ? 32'd0 : {27'd0, rd});
    next();
  endtask

  logic [31:0] cnt0;
  initial begin
    repeat (2) @(posedge clk);
    #1 reset_n = 1'b1;
    started = 1'b1;
    @(negedge clk);
    check("reset_addr", {27'd0, rd_address}, 32'd0);
    check("reset_value", rd_value, 32'd0);
    check("reset_count", retire_count, 32'd0);
    next();
    alu_valid = 1'b1; alu_rd = 5'd4; alu_value = 32'd546;
    @(negedge clk); check("alu_ready_lit", {31'd0, alu_ready}, 32'd1);
    next(); idle();
    @(negedge clk);
    check("alu_addr_lit", {27'd0, rd_address}, 32'd4);
    check("alu_value_lit", rd_value, 32'd546);
    next();
    @(negedge clk); check("alu_idle_lit", {27'd0, rd_address}, 32'd0);
    next();
    do_load("lb3", 3'b000, 2'd3, 5'd9, 32'hFFFF_FF80, 1'b0);
    do_load("lbu2", 3'b100, 2'd2, 5'd10, 32'h0000_00F0, 1'b0);
    do_load("lhu2", 3'b101, 2'd2, 5'd11, 32'h0000_80F0, 1'b0);
    do_load("lh0", 3'b001, 2'd0, 5'd12, 32'h0000_1234, 1'b0);
    do_load("lh2", 3'b001, 2'd2, 5'd13, 32'hFFFF_80F0, 1'b0);
    do_load("lw0", 3'b010, 2'd0, 5'd14, 32'h80F0_1234, 1'b0);
    do_load("lw1", 3'b010, 2'd1, 5'd7, 32'd0, 1'b1);
    do_load("lh1", 3'b001, 2'd1, 5'd8, 32'd0, 1'b1);
    do_load("f3_011", 3'b011, 2'd0, 5'd15, 32'd0, 1'b1);
    // Both sources held: LSU, LSU, ALU, LSU.
    alu_valid = 1'b1; alu_rd = 5'd1; alu_value = 32'h11;
    lsu_valid = 1'b1; lsu_rd = 5'd2; lsu_funct3 = 3'b010; lsu_addr_lo = 2'd0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("starve_alu", {31'd0, alu_ready}, (i == 2) ? 32'd1 : 32'd0);
      check("starve_lsu", {31'd0, lsu_ready}, (i == 2) ? 32'd0 : 32'd1);
      next();
    end
    idle(); next();
    cnt0 = retire_count;
    alu_valid = 1'b1; alu_rd = 5'd0; alu_value = 32'd654;
    @(negedge clk); check("x0_ready", {31'd0, alu_ready}, 32'd1);
    next(); idle();
    @(negedge clk);
    check("x0_addr", {27'd0, rd_address}, 32'd0);
`ifdef WB_RETIRE_CNT_EN
    check("x0_count", retire_count - cnt0, 32'd1);
`else
    check("x0_count", retire_count - cnt0, 32'd0);
`endif
    next();
    for (int i = 0; i < 60; i++) begin
      alu_valid = 1'($urandom); alu_rd = 5'($urandom); alu_value = $urandom;
      lsu_valid = 1'($urandom); lsu_rd = 5'($urandom); lsu_data = $urandom;
      lsu_addr_lo = 2'($urandom); lsu_funct3 = 3'($urandom);
      next();
    end
    alu_valid = 1'b1; alu_rd = 5'd4; alu_value = 32'd100; lsu_valid = 1'b0;
    next(); idle();
    #2 reset_n = 1'b0;
    #1;
    check("rst_mid_addr", {27'd0, rd_address}, 32'd0);
    check("rst_mid_value", rd_value, 32'd0);
    check("rst_mid_count", retire_count, 32'd0);
    reset_n = 1'b1;
    next(); next();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/rv32_writeback.md
# rv32_writeback

Writeback stage of the RV32 core. It accepts results from the execute unit (ALU) and the load/store unit (LSU) over valid/ready channels and drives the register file write port. It aligns and sign- or zero-extends load data, arbitrates between the two sources without starving the ALU, and flags bad loads. It is the only writer of the register file; the register file read ports serve decode.

## Interface
Parameters:
- XLEN, 32, datapath width.
- ALU_STARVE_LIMIT, 2, consecutive lost ALU cycles before the ALU gets priority.

Ports:
- clk  in  1  core clock; all state updates on its rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- alu_valid  in  1  ALU result offered.
- alu_ready  out  1  ALU result accepted this cycle.
- alu_rd  in  5  ALU destination register.
- alu_value  in  XLEN  ALU result.
- lsu_valid  in  1  load result offered.
- lsu_ready  out  1  load result accepted this cycle.
- lsu_rd  in  5  load destination register.
- lsu_data  in  XLEN  raw aligned memory word.
- lsu_addr_lo  in  2  byte offset of the load address.
- lsu_funct3  in  3  load type.
- rd_address  out  5  register file write address; 0 when idle.
- rd_value  out  XLEN  register file write data; 0 when idle.
- load_err  out  1  one-cycle pulse on a misaligned or illegal load.
- retire_count  out  32  accepted-transaction count (only with WB_RETIRE_CNT_EN).

## Operation
- The register file write port has no enable, so writing x0 is a no-op. Idle cycles drive rd_address=0 and rd_value=0.
- At most one transaction is accepted per cycle. Ready is combinational from the valids and the priority state. A transaction is accepted when valid && ready.
- Arbitration:
  - Default priority goes to the LSU.
  - alu_wait counter: increments each cycle alu_valid is high and the ALU is not granted, saturating at ALU_STARVE_LIMIT. It clears on ALU grant.
  - When alu_wait == ALU_STARVE_LIMIT, the ALU wins over the LSU.
  - With a single requester, that requester is granted.
- Load extraction, by funct3:
  - 000 LB: byte at lsu_addr_lo, sign-extended.
  - 100 LBU: same byte, zero-extended.
  - 001 LH: halfword at lsu_addr_lo[1], sign-extended.
  - 101 LHU: same halfword, zero-extended.
  - 010 LW: full word.
- Load errors:
  - Conditions: LH/LHU with lsu_addr_lo[0]=1, LW with lsu_addr_lo!=0, or any other funct3 value.
  - The transaction is still consumed (lsu_ready high). load_err pulses and no write occurs: rd_address=0.
- A destination of x0 is accepted normally and produces rd_address=0.

## Timing
- Reset (asynchronous, any time, including mid-transaction):
  - rd_address=0, rd_value=0, load_err=0, alu_wait=0, retire_count=0.
  - Any pending grant is dropped.
- Latency: a transaction accepted at edge N drives rd_address/rd_value for exactly the cycle after edge N. The register file captures it at edge N+1.
- Back-to-back accepts give continuous writes with no bubble. The outputs return to 0 one cycle after the last accept.
- load_err is registered alongside rd_address and is high for one cycle.
- Simultaneous valids with alu_wait < limit: LSU granted. With alu_wait == limit: ALU granted and alu_wait cleared.

## Configuration
- WB_RETIRE_CNT_EN defined:
  - retire_count increments by 1 per accepted transaction, including x0 destinations and errored loads.
  - It wraps from 0xFFFFFFFF to 0.
- WB_RETIRE_CNT_EN undefined: the counter logic is removed and retire_count is tied to 0.

## Structure
- Shared package rv32_pkg holds XLEN and the load funct3 constants (LB, LH, LW, LBU, LHU).
- One sub-module, rv32_load_align: combinational; takes data, addr_lo and funct3; produces the extended value and an error flag.
- The arbiter, alu_wait counter, output registers and retire counter stay in rv32_writeback.

## Test plan
- ALU only: alu_rd=4, alu_value=546 → alu_ready=1; next cycle rd_address=4, rd_value=546; following cycle rd_address=0.
- Loads with lsu_data=0x80F0_1234:
  - LB, addr_lo=3 → 0xFFFF_FF80.
  - LBU, addr_lo=2 → 0x0000_00F0.
  - LHU, addr_lo=2 → 0x0000_80F0.
  - LH, addr_lo=0 → 0x0000_1234.
- Misaligned load: LW, addr_lo=1, lsu_rd=7 → lsu_ready=1; next cycle load_err=1 and rd_address=0.
- Starvation: both valids held high → LSU granted for 2 cycles, ALU granted on cycle 3, LSU granted on cycle 4.
- x0 write: alu_rd=0, alu_value=654 → accepted; rd_address=0; retire_count increments when WB_RETIRE_CNT_EN is defined.
- Reset mid-stream: reset_n low between edges while rd_address=4 → rd_address, rd_value and retire_count go to 0 immediately, before the next clock edge.
